// File: rtl/mult_acc_pkg.sv
// Shared types and constants for the multiply-accumulate readout stage.
// No logic; imported by mult_accumulator and acc_byte_serializer.
// Holds the FSM state encoding and default widths.
package mult_acc_pkg;

    localparam int BYTE_W    = 8;
    localparam int ACC_W_DEF = 16;
    localparam int CNT_W_DEF = 4;

    typedef enum logic {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } state_t;

endpackage

// File: rtl/acc_byte_serializer.sv
// Loads an accumulator snapshot and presents it LSB byte first on a valid/ready port.
// First byte valid the cycle after load; one byte per cycle while out_ready is high.
// out_ready low holds out_data/out_valid stable; done pulses with the last byte handshake.
module acc_byte_serializer
    import mult_acc_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [ACC_W-1:0] snap,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_valid,
    output logic             done
);

    localparam int NB    = ACC_W / BYTE_W;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

    logic [ACC_W-1:0] shreg;
    logic [ACC_W-1:0] nxt;
    logic [IDX_W-1:0] idx;
    logic             take;
    logic             last;

    assign nxt  = shreg >> BYTE_W;
    assign last = (idx == IDX_W'(NB - 1));
    assign take = out_valid & out_ready;
    assign done = take & last;

    // Snapshot load, byte index advance and registered output byte
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg     <= '0;
            idx       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            shreg     <= snap;
            idx       <= '0;
            out_valid <= 1'b1;
            out_data  <= snap[BYTE_W-1:0];
        end else if (take) begin
            if (last) begin
                idx       <= '0;
                out_valid <= 1'b0;
            end else begin
                idx      <= idx + IDX_W'(1);
                shreg    <= nxt;
                out_data <= nxt[BYTE_W-1:0];
            end
        end
    end

endmodule

// File: rtl/mult_accumulator.sv
// Sums 8-bit products into an ACC_W accumulator and reads it out byte-serially (MULT_ACC_SAT_EN: saturate instead of wrap).
// Accumulate: updated on the accepting edge; readout: first byte the cycle after rd_start.
// prod_ready drops for the whole drain; out_ready low stalls the drain with data held.
module mult_accumulator
    import mult_acc_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       prod_in,
    input  logic             prod_valid,
    output logic             prod_ready,
    input  logic             clr,
    input  logic             rd_start,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             ovf,
    output logic [CNT_W-1:0] count,
    output logic             busy
);

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] prod_ext;
    logic             accept;
    logic             load;
    logic             done;

    assign prod_ready = (state == ACCUM);
    assign busy       = (state == DRAIN);
    assign accept     = prod_valid & prod_ready;
    assign load       = rd_start & (state == ACCUM);
    assign prod_ext   = {{(ACC_W-BYTE_W){1'b0}}, prod_in};
    assign sum        = {1'b0, acc} + {1'b0, prod_ext};

    // Readout FSM: leave ACCUM on rd_start, return once the last byte is taken
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ACCUM;
        end else begin
            case (state)
                ACCUM:   if (rd_start) state <= DRAIN;
                DRAIN:   if (done)     state <= ACCUM;
                default:               state <= ACCUM;
            endcase
        end
    end

    // Accumulator, saturating product counter and sticky overflow flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (clr) begin
            // A product accepted alongside clr starts the new sum
            acc   <= accept ? prod_ext : '0;
            count <= accept ? CNT_W'(1) : '0;
            ovf   <= 1'b0;
        end else if (accept) begin
            if (count != {CNT_W{1'b1}}) count <= count + CNT_W'(1);
            if (sum[ACC_W]) ovf <= 1'b1;
`ifdef MULT_ACC_SAT_EN
            acc <= sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
            acc <= sum[ACC_W-1:0];
`endif
        end
    end

    // Snapshot taken from the pre-add accumulator value
    acc_byte_serializer #(.ACC_W(ACC_W)) u_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .snap      (acc),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .done      (done)
    );

endmodule

// File: tb/tb_mult_accumulator.sv
// Directed bench for mult_accumulator: expected bytes go into a queue,
// a monitor pops and compares on each output handshake.
module tb_mult_accumulator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] prod_in;
    logic       prod_valid;
    logic       prod_ready;
    logic       clr;
    logic       rd_start;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       ovf;
    logic [3:0] count;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    mult_accumulator dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .prod_in    (prod_in),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .clr        (clr),
        .rd_start   (rd_start),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ovf        (ovf),
        .count      (count),
        .busy       (busy)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every output handshake consumes one expected byte
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_byte: got 0x%0h with empty queue", out_data);
            end else begin
                check("out_byte", {8'h00, out_data}, {8'h00, exp_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] p);
        prod_in    = p;
        prod_valid = 1'b1;
        tick();
        prod_valid = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 40 && busy; i++) tick();
        @(negedge clk);
        check({name, "_ready_after"}, {15'd0, prod_ready}, 16'd1);
        #1;
    endtask

    // Queue the two expected bytes, start the drain with out_ready high, wait for it to finish
    task automatic drain(input string name, input logic [15:0] exp);
        exp_q.push_back(exp[7:0]);
        exp_q.push_back(exp[15:8]);
        out_ready = 1'b1;
        rd_start  = 1'b1;
        tick();
        rd_start  = 1'b0;
        wait_idle(name);
    endtask

    initial begin
        logic [15:0] exp_big;
        rst_n = 1'b0; prod_in = '0; prod_valid = 1'b0; clr = 1'b0;
        rd_start = 1'b0; out_ready = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid",  {15'd0, out_valid},  16'd0);
        check("rst_busy",       {15'd0, busy},       16'd0);
        check("rst_prod_ready", {15'd0, prod_ready}, 16'd1);
        check("rst_count",      {12'd0, count},      16'd0);
        check("rst_ovf",        {15'd0, ovf},        16'd0);
        check("rst_out_data",   {8'd0, out_data},    16'd0);
        #1;

        // 3 x 225 = 675 = 0x02A3
        do_clr();
        for (int i = 0; i < 3; i++) push(8'd225);
        check("three_count", {12'd0, count}, 16'd3);
        check("three_ovf",   {15'd0, ovf},   16'd0);
        drain("three", 16'h02A3);

        // 292 x 225 = 65700 = 0x100A4 overflows 16 bits
        do_clr();
        for (int i = 0; i < 292; i++) push(8'd225);
        check("ovf_flag",  {15'd0, ovf},   16'd1);
        check("ovf_count", {12'd0, count}, 16'd15);
`ifdef MULT_ACC_SAT_EN
        exp_big = 16'hFFFF;
`else
        exp_big = 16'h00A4;
`endif
        drain("ovf", exp_big);

        // Build 0x1234 = 18 x 0xFF + 0x46, then stall the drain
        do_clr();
        check("clr_ovf", {15'd0, ovf}, 16'd0);
        for (int i = 0; i < 18; i++) push(8'hFF);
        push(8'h46);
        exp_q.push_back(8'h34);
        exp_q.push_back(8'h12);
        out_ready = 1'b0;
        rd_start  = 1'b1;
        tick();
        prod_valid = 1'b1;
        prod_in    = 8'h01;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_data",       {8'd0, out_data},    16'h0034);
            check("stall_valid",      {15'd0, out_valid},  16'd1);
            check("stall_prod_ready", {15'd0, prod_ready}, 16'd0);
            check("stall_busy",       {15'd0, busy},       16'd1);
            #1;
            tick();
        end
        rd_start   = 1'b0;
        prod_valid = 1'b0;
        out_ready  = 1'b1;
        wait_idle("stall");
        drain("stall_again", 16'h1234);

        // clr with an accepted product: acc 0x0100 -> 0x0040
        do_clr();
        push(8'h80);
        push(8'h80);
        clr = 1'b1; prod_valid = 1'b1; prod_in = 8'h40;
        tick();
        clr = 1'b0; prod_valid = 1'b0;
        check("clracc_count", {12'd0, count}, 16'd1);
        check("clracc_ovf",   {15'd0, ovf},   16'd0);
        drain("clracc", 16'h0040);

        // Reset after the first byte of a drain is taken
        do_clr();
        push(8'h11);
        exp_q.push_back(8'h11);
        out_ready = 1'b1;
        rd_start  = 1'b1;
        tick();
        rd_start  = 1'b0;
        tick();
        rst_n     = 1'b0;
        out_ready = 1'b0;
        tick();
        rst_n     = 1'b1;
        @(negedge clk);
        check("midrst_out_valid",  {15'd0, out_valid},  16'd0);
        check("midrst_busy",       {15'd0, busy},       16'd0);
        check("midrst_prod_ready", {15'd0, prod_ready}, 16'd1);
        check("midrst_count",      {12'd0, count},      16'd0);
        #1;
        drain("midrst", 16'h0000);

        // rd_start together with an accepted product
        do_clr();
        push(8'h05);
        exp_q.push_back(8'h05);
        exp_q.push_back(8'h00);
        out_ready  = 1'b1;
        rd_start   = 1'b1;
        prod_valid = 1'b1;
        prod_in    = 8'h10;
        tick();
        rd_start   = 1'b0;
        prod_valid = 1'b0;
        wait_idle("same");
        check("same_count", {12'd0, count}, 16'd2);
        drain("same_after", 16'h0015);

        tick(); tick();
        check("queue_empty", 16'(exp_q.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
